bus_responder: RTL and testbench

Responder end of the `active`/`ready`/`data` single-bit handshake bus. The initiator drives `active`. This block buffers words from a local producer in a small FIFO and drives `ready` and the tri-state `data` line. It shifts each word out LSB-first, one bit per accepted cycle. Every protocol rule the bus checker enforces holds here by construction.

---
 rtl/bus_responder.sv | 139 +++++++++++++
 tb/tb_bus_responder.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_responder.sv
// bus_responder: responder end of the active/ready/data serial handshake bus.
// Buffers producer words in a FIFO and shifts them out LSB-first. Rev 1.0
`default_nettype none

module bus_responder #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     active,
  output logic                     ready,
  inout  wire                      data,
  input  logic                     wr_valid,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     wr_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     word_done,
  output logic                     abort
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      count;
  logic [BW-1:0]      bit_idx;
  logic [WIDTH-1:0]   head;

  logic push;
  logic pop;
  logic beat;
  logic last_beat;
  logic avail_next;
  logic more_after_pop;

  assign wr_ready   = (count != FULL);
  assign fifo_count = count;
  assign push       = wr_valid && wr_ready;
  assign beat       = active && ready;
  assign last_beat  = beat && (bit_idx == LAST_BIT);
  assign pop        = last_beat;
  assign head       = mem[rd_ptr];

  // A word pushed on the same edge already counts as available.
  assign avail_next     = (count != '0) || push;
  assign more_after_pop = (count > CW'(1)) || push;

  assign data = beat ? head[bit_idx] : 1'bz;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ready     <= 1'b0;
      bit_idx   <= '0;
      word_done <= 1'b0;
      abort     <= 1'b0;
    end else begin
      word_done <= 1'b0;
      abort     <= 1'b0;
      if (!active) begin
        // Window closed: a partial word stays queued and restarts from bit 0.
        state   <= IDLE;
        ready   <= 1'b0;
        bit_idx <= '0;
        if (bit_idx != '0) begin
          abort <= 1'b1;
        end
      end else begin
        case (state)
          IDLE, STALL: begin
            if (avail_next) begin
              state   <= SEND;
              ready   <= 1'b1;
              bit_idx <= '0;
            end else begin
              state <= STALL;
              ready <= 1'b0;
            end
          end
          SEND: begin
            if (bit_idx == LAST_BIT) begin
              word_done <= 1'b1;
              bit_idx   <= '0;
              if (!more_after_pop) begin
                state <= STALL;
                ready <= 1'b0;
              end
            end else begin
              bit_idx <= bit_idx + BW'(1);
            end
          end
          default: begin
            state   <= IDLE;
            ready   <= 1'b0;
            bit_idx <= '0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bus_responder.sv
// tb_bus_responder: directed scenarios plus randomized traffic against a queue model.
// Rev 1.0
`default_nettype none

module tb_bus_responder;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       active = 1'b0;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = 8'h00;
  wire        data;
  logic       ready;
  logic       wr_ready;
  logic [2:0] fifo_count;
  logic       word_done;
  logic       abort;

  // Bench-side driver used only to tell a released line from a driven one.
  logic probe_en = 1'b0;
  logic probe_val = 1'b0;
  assign data = probe_en ? probe_val : 1'bz;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  bus_responder #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .active     (active),
    .ready      (ready),
    .data       (data),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .fifo_count (fifo_count),
    .word_done  (word_done),
    .abort      (abort)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Line follows the bench driver both ways only if the responder is not driving.
  task automatic probe_released(output bit released);
    logic r0, r1;
    probe_en = 1'b1;
    probe_val = 1'b0;
    #1;
    r0 = data;
    probe_val = 1'b1;
    #1;
    r1 = data;
    probe_en = 1'b0;
    #1;
    released = (r0 === 1'b0) && (r1 === 1'b1);
  endtask

  task automatic test_reset();
    bit rel;
    rst_n = 1'b0; active = 1'b0; wr_valid = 1'b0;
    cyc(); cyc();
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", ready); end
    total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
    total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL reset_wr_ready got=%b exp=1", wr_ready); end
    total++; if (word_done !== 1'b0 || abort !== 1'b0) begin bad++; $display("FAIL reset_pulses got=%b%b exp=00", word_done, abort); end
    probe_released(rel);
    total++; if (!rel) begin bad++; $display("FAIL reset_data_z got=driven exp=released"); end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_single_word();
    logic [7:0] w;
    bit rel;
    w = 8'hA5;
    wr_data = w; wr_valid = 1'b1;
    cyc();
    wr_valid = 1'b0;
    total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", fifo_count); end
    active = 1'b1;
    probe_released(rel);
    total++; if (ready !== 1'b0 || !rel) begin bad++; $display("FAIL single_pre ready=%b released=%b exp ready=0 released=1", ready, rel); end
    cyc();
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL single_ready_rise got=%b exp=1", ready); end
    for (int k = 0; k < 8; k++) begin
      total++; if (data !== w[k]) begin bad++; $display("FAIL single_bit%0d got=%b exp=%b", k, data, w[k]); end
      cyc();
      total++; if (word_done !== (k == 7)) begin bad++; $display("FAIL single_done%0d got=%b exp=%b", k, word_done, (k == 7)); end
    end
    total++; if (ready !== 1'b0 || fifo_count !== 3'd0) begin bad++; $display("FAIL single_end ready=%b count=%0d exp ready=0 count=0", ready, fifo_count); end
    cyc();
    total++; if (ready !== 1'b0 || word_done !== 1'b0) begin bad++; $display("FAIL single_stall ready=%b done=%b exp 0 0", ready, word_done); end
    active = 1'b0;
    cyc();
  endtask

  task automatic test_back_to_back();
    logic [15:0] stream;
    stream = 16'hF00F;
    wr_data = 8'h0F; wr_valid = 1'b1; cyc();
    wr_data = 8'hF0; cyc();
    wr_valid = 1'b0;
    active = 1'b1;
    cyc();
    for (int b = 0; b < 16; b++) begin
      total++; if (ready !== 1'b1 || data !== stream[b]) begin bad++; $display("FAIL b2b_beat%0d ready=%b data=%b exp ready=1 data=%b", b, ready, data, stream[b]); end
      cyc();
      total++; if (word_done !== (b == 7 || b == 15)) begin bad++; $display("FAIL b2b_done%0d got=%b exp=%b", b, word_done, (b == 7 || b == 15)); end
    end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL b2b_end_ready got=%b exp=0", ready); end
    active = 1'b0;
    cyc();
  endtask

  task automatic test_empty_stall();
    logic [7:0] w;
    bit rel;
    w = 8'h3C;
    active = 1'b1;
    for (int c = 0; c < 4; c++) begin
      probe_released(rel);
      total++; if (ready !== 1'b0 || !rel) begin bad++; $display("FAIL stall_c%0d ready=%b released=%b exp 0 1", c, ready, rel); end
      if (c == 3) begin
        wr_data = w; wr_valid = 1'b1;
      end
      cyc();
    end
    wr_valid = 1'b0;
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL stall_ready_after_push got=%b exp=1", ready); end
    for (int k = 0; k < 8; k++) begin
      total++; if (data !== w[k]) begin bad++; $display("FAIL stall_bit%0d got=%b exp=%b", k, data, w[k]); end
      cyc();
    end
    total++; if (word_done !== 1'b1) begin bad++; $display("FAIL stall_done got=%b exp=1", word_done); end
    active = 1'b0;
    cyc();
  endtask

  task automatic test_abort();
    bit rel;
    wr_data = 8'hFF; wr_valid = 1'b1; cyc();
    wr_valid = 1'b0;
    active = 1'b1;
    cyc(); cyc(); cyc(); cyc();
    active = 1'b0;
    probe_released(rel);
    total++; if (!rel) begin bad++; $display("FAIL abort_data_z got=driven exp=released"); end
    cyc();
    total++; if (abort !== 1'b1 || ready !== 1'b0 || fifo_count !== 3'd1) begin bad++; $display("FAIL abort_pulse abort=%b ready=%b count=%0d exp 1 0 1", abort, ready, fifo_count); end
    cyc();
    total++; if (abort !== 1'b0) begin bad++; $display("FAIL abort_one_cycle got=%b exp=0", abort); end
    active = 1'b1;
    cyc();
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL abort_reopen_ready got=%b exp=1", ready); end
    for (int k = 0; k < 8; k++) begin
      total++; if (data !== 1'b1) begin bad++; $display("FAIL abort_resend_bit%0d got=%b exp=1", k, data); end
      cyc();
      total++; if (word_done !== (k == 7)) begin bad++; $display("FAIL abort_resend_done%0d got=%b exp=%b", k, word_done, (k == 7)); end
    end
    total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL abort_end_count got=%0d exp=0", fifo_count); end
    active = 1'b0;
    cyc();
  endtask

  task automatic test_full_fifo();
    logic [7:0] words [5];
    logic [7:0] w;
    words = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
    for (int i = 0; i < 5; i++) begin
      wr_data = words[i]; wr_valid = 1'b1;
      #1;
      total++; if (wr_ready !== (i < 4)) begin bad++; $display("FAIL full_wr_ready%0d got=%b exp=%b", i, wr_ready, (i < 4)); end
      cyc();
    end
    wr_valid = 1'b0;
    total++; if (fifo_count !== 3'd4 || wr_ready !== 1'b0) begin bad++; $display("FAIL full_count count=%0d wr_ready=%b exp 4 0", fifo_count, wr_ready); end
    active = 1'b1;
    cyc();
    for (int j = 0; j < 4; j++) begin
      w = words[j];
      for (int b = 0; b < 8; b++) begin
        total++; if (data !== w[b]) begin bad++; $display("FAIL full_drain w%0d b%0d got=%b exp=%b", j, b, data, w[b]); end
        cyc();
      end
    end
    total++; if (fifo_count !== 3'd0 || ready !== 1'b0) begin bad++; $display("FAIL full_drained count=%0d ready=%b exp 0 0", fifo_count, ready); end
    active = 1'b0;
    cyc();
  endtask

  task automatic test_reset_mid_word();
    bit rel;
    wr_data = 8'h96; wr_valid = 1'b1; cyc();
    wr_data = 8'h69; cyc();
    wr_valid = 1'b0;
    active = 1'b1;
    cyc(); cyc(); cyc(); cyc(); cyc();
    rst_n = 1'b0;
    #1;
    total++; if (ready !== 1'b0 || fifo_count !== 3'd0) begin bad++; $display("FAIL rstmid_async ready=%b count=%0d exp 0 0", ready, fifo_count); end
    probe_released(rel);
    total++; if (!rel) begin bad++; $display("FAIL rstmid_data_z got=driven exp=released"); end
    active = 1'b0;
    cyc();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cyc();
      total++; if (ready !== 1'b0 || wr_ready !== 1'b1) begin bad++; $display("FAIL rstmid_after%0d ready=%b wr_ready=%b exp 0 1", c, ready, wr_ready); end
    end
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    logic [7:0] hd;
    logic       m_ready;
    int         m_idx;
    logic       m_done;
    logic       m_abort;
    bit         push;
    bit         rel;
    m_ready = 1'b0; m_idx = 0; m_done = 1'b0; m_abort = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 6) == 0) active = ~active;
      wr_valid = ($urandom_range(0, 2) == 0);
      wr_data = 8'($urandom);
      #1;
      if (active && m_ready) begin
        hd = q[0];
        total++; if (data !== hd[m_idx]) begin bad++; $display("FAIL rnd_data n=%0d got=%b exp=%b", n, data, hd[m_idx]); end
      end else begin
        probe_released(rel);
        total++; if (!rel) begin bad++; $display("FAIL rnd_data_z n=%0d got=driven exp=released", n); end
      end
      total++; if (ready !== m_ready) begin bad++; $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, ready, m_ready); end
      total++; if (fifo_count !== 3'(q.size())) begin bad++; $display("FAIL rnd_count n=%0d got=%0d exp=%0d", n, fifo_count, q.size()); end
      total++; if (wr_ready !== (q.size() != DEPTH)) begin bad++; $display("FAIL rnd_wr_ready n=%0d got=%b exp=%b", n, wr_ready, (q.size() != DEPTH)); end
      total++; if (word_done !== m_done || abort !== m_abort) begin bad++; $display("FAIL rnd_pulses n=%0d got=%b%b exp=%b%b", n, word_done, abort, m_done, m_abort); end
      push = wr_valid && (q.size() < DEPTH);
      m_done = 1'b0;
      m_abort = 1'b0;
      if (!active) begin
        m_abort = (m_idx != 0);
        m_ready = 1'b0;
        m_idx = 0;
      end else if (!m_ready) begin
        m_ready = (q.size() != 0) || push;
      end else if (m_idx == WIDTH - 1) begin
        m_done = 1'b1;
        m_idx = 0;
        void'(q.pop_front());
        m_ready = (q.size() != 0) || push;
      end else begin
        m_idx++;
      end
      if (push) q.push_back(wr_data);
      cyc();
    end
    active = 1'b0;
    wr_valid = 1'b0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_empty_stall();
    test_abort();
    test_full_fifo();
    test_reset_mid_word();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
